// File: rtl/ps2_host_ctrl.sv
// PS/2 host link controller: sequences inbound device frames into the scan-code FIFO
// and sends host command bytes over the open-drain clock/data pull-downs.
module ps2_host_ctrl #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned START_TIMEOUT  = 1500000,
  parameter int unsigned BIT_TIMEOUT    = 8190
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_edge,
  input  logic       ps2_data,
  input  logic       okay,
  output logic       shift,
  output logic       write,
  output logic       rx_err,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned TMR_MAX = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BIT_LAST   = TMR_W'(BIT_TIMEOUT - 1);
  localparam logic [INH_W-1:0] INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    RX_WAIT,
    RX_CHECK,
    TX_INHIBIT,
    TX_RTS,
    TX_WAIT_START,
    TX_BITS,
    TX_ACK,
    TX_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [8:0]       tx_sr_q, tx_sr_d;
  logic             err_q, err_d;
  logic             shift_q, shift_d;
  logic             write_q, write_d;
  logic             rx_err_q, rx_err_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             timed;

  always_comb begin
    // NOTE: every signal gets its default before the case, so no path can infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tx_sr_d   = tx_sr_q;
    err_d     = err_q;
    dat_oe_d  = dat_oe_q;
    shift_d   = 1'b0;
    write_d   = 1'b0;
    rx_err_d  = 1'b0;
    timer_d   = '0;

    // The ack bit is still inside the frame, so the gap timer also covers TX_ACK.
    timed = (state_q == RX_WAIT) || (state_q == TX_WAIT_START) ||
            (state_q == TX_BITS) || (state_q == TX_ACK);
    if (timed) begin
      if (ps2_edge)            timer_d = '0;
      else if (timer_q == '1)  timer_d = timer_q;
      else                     timer_d = timer_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        dat_oe_d = 1'b0;
        if (ps2_edge) begin
          shift_d   = 1'b1;
          bit_cnt_d = 4'd1;
          state_d   = RX_WAIT;
        end else if (tx_req) begin
          tx_sr_d   = {~^tx_data, tx_data};
          err_d     = 1'b0;
          inh_cnt_d = '0;
          state_d   = TX_INHIBIT;
        end
      end

      // The 11th shift must land in the shifter before okay is consulted.
      RX_WAIT: begin
        if (bit_cnt_q == 4'd11) begin
          state_d = RX_CHECK;
        end else if (ps2_edge) begin
          shift_d   = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (timer_q == BIT_LAST) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      RX_CHECK: begin
        write_d  = okay;
        rx_err_d = ~okay;
        state_d  = IDLE;
      end

      TX_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          state_d  = TX_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      TX_RTS: state_d = TX_WAIT_START;

      // Shifting ones in behind the byte makes the 10th edge release the data line.
      TX_WAIT_START, TX_BITS: begin
        if (ps2_edge) begin
          dat_oe_d  = ~tx_sr_q[0];
          tx_sr_d   = {1'b1, tx_sr_q[8:1]};
          bit_cnt_d = (state_q == TX_WAIT_START) ? 4'd1 : bit_cnt_q + 1'b1;
          if (state_q == TX_WAIT_START) state_d = TX_BITS;
          else if (bit_cnt_q == 4'd9)   state_d = TX_ACK;
        end else if ((state_q == TX_WAIT_START) ? (timer_q == START_LAST)
                                                : (timer_q == BIT_LAST)) begin
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = TX_DONE;
        end
      end

      TX_ACK: begin
        if (ps2_edge) begin
          err_d   = ps2_data;
          state_d = TX_DONE;
        end else if (timer_q == BIT_LAST) begin
          err_d   = 1'b1;
          state_d = TX_DONE;
        end
      end

      TX_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    clk_oe_d = (state_d == TX_INHIBIT) || (state_d == TX_RTS);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      timer_q   <= '0;
      tx_sr_q   <= '0;
      err_q     <= 1'b0;
      shift_q   <= 1'b0;
      write_q   <= 1'b0;
      rx_err_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      timer_q   <= timer_d;
      tx_sr_q   <= tx_sr_d;
      err_q     <= err_d;
      shift_q   <= shift_d;
      write_q   <= write_d;
      rx_err_q  <= rx_err_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
    end
  end

  assign shift      = shift_q;
  assign write      = write_q;
  assign rx_err     = rx_err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_busy    = (state_q == TX_INHIBIT) || (state_q == TX_RTS) ||
                      (state_q == TX_WAIT_START) || (state_q == TX_BITS) ||
                      (state_q == TX_ACK) || (state_q == TX_DONE);
  assign tx_done    = (state_q == TX_DONE);
  assign tx_err     = tx_done & err_q;

endmodule
